// File: rtl/mem_bus_pkg.sv
// Shared encodings for the picorv32 native-bus interconnect: FSM states,
// error causes and the default error read data.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [1:0]  ERR_NONE          = 2'b00;
    localparam logic [1:0]  ERR_UNMAPPED      = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT       = 2'b10;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Table-driven address decode: masked compare against each target's base,
// lowest matching index wins.
module mem_bus_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int                      N_TARGETS = 8,
    parameter int                      SEL_W     = sel_width(N_TARGETS),
    parameter logic [32*N_TARGETS-1:0] BASE      = {N_TARGETS{32'h0}},
    parameter logic [32*N_TARGETS-1:0] MASK      = {N_TARGETS{32'hFF00_0000}}
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        // Scan downward so the lowest matching index is the last one written.
        for (int i = N_TARGETS - 1; i >= 0; i--) begin
            if ((addr & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32])) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_interconnect.sv
// One-master / N-target picorv32 bus interconnect with latched target select,
// registered response path, unmapped/timeout error responses and sticky capture.
module mem_bus_interconnect
    import mem_bus_pkg::*;
#(
    parameter int                      N_TARGETS      = 8,
    parameter logic [32*N_TARGETS-1:0] BASE           = {N_TARGETS{32'h0}},
    parameter logic [32*N_TARGETS-1:0] MASK           = {N_TARGETS{32'hFF00_0000}},
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter int                      TO_BITS        = 8,
    parameter logic [31:0]             ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_wstrb,
    output logic                      mem_ready,
    output logic [31:0]               mem_rdata,
    output logic [N_TARGETS-1:0]      t_valid,
    output logic [31:0]               t_addr,
    output logic [31:0]               t_wdata,
    output logic [3:0]                t_wstrb,
    input  logic [N_TARGETS-1:0]      t_ready,
    input  logic [32*N_TARGETS-1:0]   t_rdata,
    input  logic                      err_clear,
    output logic                      err_pulse,
    output logic                      err_valid,
    output logic [1:0]                err_cause,
    output logic [31:0]               err_addr
);

    localparam int                 SEL_W   = sel_width(N_TARGETS);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   dec_sel;
    logic               hit;
    logic               hold;
    logic [TO_BITS-1:0] cnt;
    logic               sel_ready;
    logic [31:0]        sel_rdata;
    logic               enter_err;
    logic [1:0]         new_cause;
    logic [31:0]        new_addr;

    mem_bus_addr_decode #(
        .N_TARGETS (N_TARGETS),
        .SEL_W     (SEL_W),
        .BASE      (BASE),
        .MASK      (MASK)
    ) u_decode (
        .addr (mem_addr),
        .hit  (hit),
        .sel  (dec_sel)
    );

    assign sel_ready = t_ready[sel];
    assign sel_rdata = t_rdata[32*sel +: 32];

    always_comb begin
        enter_err = 1'b0;
        new_cause = ERR_NONE;
        new_addr  = mem_addr;
        if (state == IDLE && mem_valid && !hold && !hit) begin
            enter_err = 1'b1;
            new_cause = ERR_UNMAPPED;
        end else if (state == ACTIVE && mem_valid && !sel_ready && cnt == TO_LAST) begin
            enter_err = 1'b1;
            new_cause = ERR_TIMEOUT;
            new_addr  = t_addr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            sel       <= '0;
            hold      <= 1'b0;
            cnt       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            t_valid   <= '0;
            t_addr    <= '0;
            t_wdata   <= '0;
            t_wstrb   <= '0;
            err_pulse <= 1'b0;
            err_valid <= 1'b0;
            err_cause <= ERR_NONE;
            err_addr  <= '0;
        end else begin
            mem_ready <= 1'b0;
            err_pulse <= 1'b0;
            hold      <= 1'b0;
            if (err_clear) begin
                err_valid <= 1'b0;
                err_cause <= ERR_NONE;
                err_addr  <= '0;
            end
            // A capture coinciding with a clear overrides the clear.
            if (enter_err && (!err_valid || err_clear)) begin
                err_valid <= 1'b1;
                err_cause <= new_cause;
                err_addr  <= new_addr;
            end
            case (state)
                IDLE: begin
                    if (mem_valid && !hold) begin
                        if (hit) begin
                            sel     <= dec_sel;
                            t_addr  <= mem_addr;
                            t_wdata <= mem_wdata;
                            t_wstrb <= mem_wstrb;
                            t_valid <= N_TARGETS'(1) << dec_sel;
                            cnt     <= '0;
                            state   <= ACTIVE;
                        end else begin
                            mem_ready <= 1'b1;
                            mem_rdata <= ERR_RDATA;
                            err_pulse <= 1'b1;
                            state     <= ERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (!mem_valid) begin
                        t_valid <= '0;
                        state   <= IDLE;
                    end else if (sel_ready) begin
                        mem_rdata <= sel_rdata;
                        mem_ready <= 1'b1;
                        t_valid   <= '0;
                        state     <= RESP;
                    end else if (cnt == TO_LAST) begin
                        mem_rdata <= ERR_RDATA;
                        mem_ready <= 1'b1;
                        err_pulse <= 1'b1;
                        t_valid   <= '0;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // The cycle after a response ignores mem_valid: picorv32 drops it a cycle late.
                RESP, ERR: begin
                    hold  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_onehot_t_valid: assert property (@(posedge clk) disable iff (!resetn) $onehot0(t_valid));

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// Scoreboard bench for mem_bus_interconnect: directed scenarios plus randomized
// transactions against an address-table/transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_bus_interconnect;

    localparam int NT = 4;
    localparam int TO = 4;
    localparam logic [32*NT-1:0] BASE_P = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h3000_0000};
    localparam logic [32*NT-1:0] MASK_P = {32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic              clk;
    logic              resetn;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [NT-1:0]     t_valid;
    logic [31:0]       t_addr;
    logic [31:0]       t_wdata;
    logic [3:0]        t_wstrb;
    logic [NT-1:0]     t_ready;
    logic [32*NT-1:0]  t_rdata;
    logic              err_clear;
    logic              err_pulse;
    logic              err_valid;
    logic [1:0]        err_cause;
    logic [31:0]       err_addr;

    mem_bus_interconnect #(
        .N_TARGETS      (NT),
        .BASE           (BASE_P),
        .MASK           (MASK_P),
        .TIMEOUT_CYCLES (TO),
        .TO_BITS        (8),
        .ERR_RDATA      (ERRD)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .t_valid   (t_valid),
        .t_addr    (t_addr),
        .t_wdata   (t_wdata),
        .t_wstrb   (t_wstrb),
        .t_ready   (t_ready),
        .t_rdata   (t_rdata),
        .err_clear (err_clear),
        .err_pulse (err_pulse),
        .err_valid (err_valid),
        .err_cause (err_cause),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        pulse;
        logic        ev;
        logic [1:0]  cause;
        logic [31:0] eaddr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference address map, written out as a table.
    logic [31:0] m_base [NT];
    logic [31:0] m_mask [NT];
    logic        m_ev;
    logic [1:0]  m_cause;
    logic [31:0] m_eaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NT; i++)
            if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (resetn && mem_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_mem_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_rdata", mem_rdata, mon_e.rdata);
                chk("resp_err_pulse", {31'd0, err_pulse}, {31'd0, mon_e.pulse});
                chk("resp_err_valid", {31'd0, err_valid}, {31'd0, mon_e.ev});
                chk("resp_err_cause", {30'd0, err_cause}, {30'd0, mon_e.cause});
                chk("resp_err_addr", err_addr, mon_e.eaddr);
            end
        end else if (resetn && err_pulse) begin
            chk("err_pulse_without_ready", 32'd1, 32'd0);
        end
    end

    // k = index of the ACTIVE cycle in which the target raises ready (k >= TO: never).
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                           input int k, input logic [31:0] rd, input bit stray, input bit lazy);
        int   tgt;
        int   n;
        int   tv;
        int   want_tv;
        bit   done;
        exp_t e;
        tgt     = ref_decode(addr);
        e.pulse = (tgt < 0) || (k >= TO);
        e.rdata = e.pulse ? ERRD : rd;
        if (e.pulse && !m_ev) begin
            m_ev    = 1'b1;
            m_cause = (tgt < 0) ? 2'b01 : 2'b10;
            m_eaddr = addr;
        end
        e.ev    = m_ev;
        e.cause = m_cause;
        e.eaddr = m_eaddr;
        sb.push_back(e);
        want_tv   = (tgt < 0) ? 0 : ((k < TO) ? k + 1 : TO);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = strb;
        n = 0; tv = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            t_ready = '0;
            t_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (mem_ready) begin
                done = 1'b1;
            end else if (t_valid != '0) begin
                chk("t_valid_select", {28'd0, t_valid}, (tgt < 0) ? 32'd0 : (32'd1 << tgt));
                if (n == 0) begin
                    chk("t_addr", t_addr, addr);
                    chk("t_wdata", t_wdata, wd);
                    chk("t_wstrb", {28'd0, t_wstrb}, {28'd0, strb});
                end
                tv++;
                if (tgt >= 0) begin
                    t_rdata[32*tgt +: 32] = rd;
                    if (n == k) t_ready[tgt] = 1'b1;
                    if (stray) t_ready = t_ready | ~(4'b0001 << tgt);
                end
                n++;
            end
        end
        if (!done) begin
            chk("mem_ready_seen", 32'd0, 32'd1);
            sb.delete();
        end
        chk("t_valid_cycles", tv, want_tv);
        if (!lazy) mem_valid = 1'b0;
        @(posedge clk); #1;
        t_ready = '0;
        chk("mem_ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        if (lazy) begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            chk("hold_no_t_valid", {28'd0, t_valid}, 32'd0);
            chk("hold_no_ready", {31'd0, mem_ready}, 32'd0);
            @(posedge clk); #1;
            chk("hold_no_t_valid2", {28'd0, t_valid}, 32'd0);
        end
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        m_ev = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0;
        chk("clear_err_valid", {31'd0, err_valid}, 32'd0);
        chk("clear_err_cause", {30'd0, err_cause}, 32'd0);
        chk("clear_err_addr", err_addr, 32'd0);
    endtask

    task automatic reset_mid_active();
        int seen;
        seen      = 0;
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0100;
        mem_wstrb = 4'h0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(posedge clk); #1;
            if (t_valid != '0) seen++;
        end
        chk("reset_mid_reached_active", seen, 32'd2);
        #2 resetn = 1'b0;
        #1;
        chk("reset_mid_t_valid", {28'd0, t_valid}, 32'd0);
        chk("reset_mid_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("reset_mid_err_valid", {31'd0, err_valid}, 32'd0);
        mem_valid = 1'b0;
        m_ev = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        m_base[0] = 32'h3000_0000; m_mask[0] = 32'hFF00_0000;
        m_base[1] = 32'h1000_0000; m_mask[1] = 32'hFF00_0000;
        m_base[2] = 32'h2000_0000; m_mask[2] = 32'hFF00_0000;
        m_base[3] = 32'h3000_0000; m_mask[3] = 32'hF000_0000;
        m_ev = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0;
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        t_ready = '0; t_rdata = '0; err_clear = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_t_valid", {28'd0, t_valid}, 32'd0);
        chk("rst_t_addr", t_addr, 32'd0);
        chk("rst_t_wdata", t_wdata, 32'd0);
        chk("rst_t_wstrb", {28'd0, t_wstrb}, 32'd0);
        chk("rst_err", {28'd0, err_pulse, err_valid, err_cause}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_txn(32'h2000_0010, 4'h0, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
        run_txn(32'h9000_0000, 4'hF, 32'hCAFE_0001, 0, 32'h0, 1'b0, 1'b0);
        do_clear();
        run_txn(32'h1000_0020, 4'h0, 32'h0, 100, 32'h0, 1'b0, 1'b0);
        run_txn(32'h9100_0004, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        do_clear();
        run_txn(32'h3000_0040, 4'h3, 32'h0BAD_F00D, 1, 32'hA5A5_0003, 1'b1, 1'b0);
        run_txn(32'h3100_0008, 4'h0, 32'h0, 0, 32'h5A5A_3333, 1'b0, 1'b1);
        run_txn(32'h1000_0030, 4'h0, 32'h0, 3, 32'h0F0F_1111, 1'b1, 1'b0);
        reset_mid_active();
        run_txn(32'h1000_0040, 4'h0, 32'h0, 0, 32'h7777_0001, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0:       a = {8'h30, 24'($urandom())};
                1:       a = {8'h10, 24'($urandom())};
                2:       a = {8'h20, 24'($urandom())};
                3:       a = {4'h3, 28'($urandom())};
                default: a = $urandom();
            endcase
            run_txn(a, 4'($urandom()), $urandom(), $urandom_range(0, 6), $urandom(),
                    1'($urandom()), 1'($urandom()));
            if ($urandom_range(0, 7) == 0) do_clear();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
